// File: rtl/pipeline_pkg.sv
// Shared types and widths for the pipeline hazard/stall controller.
package pipeline_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} ctrl_state_t;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> controller signals; master is the pipeline datapath, slave the controller.
interface pipeline_ctrl_if import pipeline_pkg::*; #(
  parameter int ADDR_WIDTH = REG_ADDR_W
) ();
  logic [ADDR_WIDTH-1:0]  ifid_rs1_i;
  logic [ADDR_WIDTH-1:0]  ifid_rs2_i;
  logic                   idex_memread_i;
  logic [ADDR_WIDTH-1:0]  idex_rd_i;
  logic                   exmem_branch_i;
  logic                   exmem_jump_i;
  logic                   exmem_comparison_i;
  logic                   exmem_memread_i;
  logic                   exmem_memwrite_i;
  logic                   dmem_ack_i;
  logic                   pc_en_o;
  logic                   ifid_en_o;
  logic                   idex_en_o;
  logic                   exmem_en_o;
  logic                   ifid_flush_o;
  logic                   idex_flush_o;
  logic                   exmem_flush_o;
  logic                   memwb_bubble_o;
  logic                   pc_sel_o;
  logic                   dmem_req_o;
  logic                   err_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output ifid_rs1_i, ifid_rs2_i, idex_memread_i, idex_rd_i, exmem_branch_i,
           exmem_jump_i, exmem_comparison_i, exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
    input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, ifid_flush_o, idex_flush_o,
           exmem_flush_o, memwb_bubble_o, pc_sel_o, dmem_req_o, err_o, stall_cnt_o
  );

  modport slave (
    input  ifid_rs1_i, ifid_rs2_i, idex_memread_i, idex_rd_i, exmem_branch_i,
           exmem_jump_i, exmem_comparison_i, exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
    output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, ifid_flush_o, idex_flush_o,
           exmem_flush_o, memwb_bubble_o, pc_sel_o, dmem_req_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard: a load in EX writes a nonzero register that the instruction in ID reads.
module hazard_detect #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  memread_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  output logic                  load_use_o
);
  assign load_use_o = memread_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: memory-wait stalls with timeout, branch/jump redirect, load-use stall,
// and a saturating stalled-cycle counter.
module pipeline_ctrl import pipeline_pkg::*; #(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
);
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]      WAIT_ONE  = 1;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE   = 1;

  ctrl_state_t            state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use, mem_access, mem_stall, redirect;
  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, exmem_flush, bubble, pc_sel, dmem_req;

  hazard_detect #(.ADDR_WIDTH(ADDR_WIDTH)) u_hazard (
    .memread_i  (bus.idex_memread_i),
    .rd_i       (bus.idex_rd_i),
    .rs1_i      (bus.ifid_rs1_i),
    .rs2_i      (bus.ifid_rs2_i),
    .load_use_o (load_use)
  );

  assign mem_access = bus.exmem_memread_i | bus.exmem_memwrite_i;
  assign mem_stall  = mem_access & ~bus.dmem_ack_i & (state_q != ERROR);
  assign redirect   = bus.exmem_jump_i | (bus.exmem_branch_i & bus.exmem_comparison_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack_i) state_d = RUN;
        else if (wait_q == WAIT_LAST) state_d = ERROR;
        else wait_d = wait_q + WAIT_ONE;
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // Output priority: reset > error > memory stall > redirect > load-use > normal.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    bubble      = 1'b0;
    pc_sel      = 1'b0;
    dmem_req    = mem_access;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      dmem_req = 1'b0;
    end else if (state_q == ERROR) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      bubble   = 1'b1;
      dmem_req = 1'b0;
    end else if (mem_stall) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      bubble = 1'b1;
    end else if (redirect) begin
      pc_sel      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  assign bus.pc_en_o        = pc_en;
  assign bus.ifid_en_o      = ifid_en;
  assign bus.idex_en_o      = idex_en;
  assign bus.exmem_en_o     = exmem_en;
  assign bus.ifid_flush_o   = ifid_flush;
  assign bus.idex_flush_o   = idex_flush;
  assign bus.exmem_flush_o  = exmem_flush;
  assign bus.memwb_bubble_o = bubble;
  assign bus.pc_sel_o       = pc_sel;
  assign bus.dmem_req_o     = dmem_req;
  assign bus.err_o          = (state_q == ERROR);
  assign bus.stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then randomized traffic vs a behavioural model.
module tb_pipeline_ctrl;
  localparam int AW = 5;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  pipeline_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic rst;
    logic [AW-1:0] rs1, rs2, rd;
    logic ld, br, jmp, cmp, mrd, mwr, ack;
  } stim_t;

  typedef struct packed {
    logic pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, exmem_fl, bubble, pc_sel, dmem_req, err;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  int    total = 0;
  int    bad   = 0;
  int    txn   = 0;

  // Behavioural model state: waiting for memory, cycles waited, sticky error, stalled cycles.
  bit    m_wait   = 0;
  int    m_waits  = 0;
  bit    m_err    = 0;
  int    m_stalls = 0;
  stim_t last;

  function automatic stim_t mk(input logic r, input int rs1, input int rs2, input int rd,
                               input logic ld, input logic br, input logic jmp, input logic cmp,
                               input logic mrd, input logic mwr, input logic ack);
    stim_t s;
    s.rst = r; s.rs1 = AW'(rs1); s.rs2 = AW'(rs2); s.rd = AW'(rd);
    s.ld = ld; s.br = br; s.jmp = jmp; s.cmp = cmp; s.mrd = mrd; s.mwr = mwr; s.ack = ack;
    return s;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit mem, lu, redir;
    e = '0;
    if (s.rst) return e;
    mem   = s.mrd || s.mwr;
    lu    = s.ld && (s.rd != 0) && (s.rd == s.rs1 || s.rd == s.rs2);
    redir = s.jmp || (s.br && s.cmp);
    e.cnt = 16'(m_stalls);
    e.ctl.err = m_err;
    if (m_err) begin
      e.ctl.bubble = 1;
    end else if (mem && !s.ack) begin
      e.ctl.bubble   = 1;
      e.ctl.dmem_req = 1;
    end else begin
      e.ctl.dmem_req = mem;
      e.ctl.pc_en = 1; e.ctl.ifid_en = 1; e.ctl.idex_en = 1; e.ctl.exmem_en = 1;
      if (redir) begin
        e.ctl.pc_sel = 1; e.ctl.ifid_fl = 1; e.ctl.idex_fl = 1; e.ctl.exmem_fl = 1;
      end else if (lu) begin
        e.ctl.pc_en = 0; e.ctl.ifid_en = 0; e.ctl.idex_fl = 1;
      end
    end
    return e;
  endfunction

  task automatic update(input stim_t s, input exp_t e);
    if (s.rst) begin
      m_wait = 0; m_waits = 0; m_err = 0; m_stalls = 0;
    end else begin
      if (!e.ctl.pc_en && m_stalls < 65535) m_stalls++;
      if (!m_err) begin
        if (m_wait) begin
          if (s.ack) m_wait = 0;
          else begin
            m_waits++;
            if (m_waits == TO) begin
              m_err  = 1;
              m_wait = 0;
            end
          end
        end else if ((s.mrd || s.mwr) && !s.ack) begin
          m_wait  = 1;
          m_waits = 0;
        end
      end
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst                    = s.rst;
    bus.ifid_rs1_i         = s.rs1;
    bus.ifid_rs2_i         = s.rs2;
    bus.idex_rd_i          = s.rd;
    bus.idex_memread_i     = s.ld;
    bus.exmem_branch_i     = s.br;
    bus.exmem_jump_i       = s.jmp;
    bus.exmem_comparison_i = s.cmp;
    bus.exmem_memread_i    = s.mrd;
    bus.exmem_memwrite_i   = s.mwr;
    bus.dmem_ack_i         = s.ack;
    e = predict(s);
    sb_q.push_back(e);
    update(s, e);
    last = s;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
  exp_t mon_e;
  ctl_t mon_a;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {bus.pc_en_o, bus.ifid_en_o, bus.idex_en_o, bus.exmem_en_o, bus.ifid_flush_o,
               bus.idex_flush_o, bus.exmem_flush_o, bus.memwb_bubble_o, bus.pc_sel_o,
               bus.dmem_req_o, bus.err_o};
      total++;
      if (mon_a !== mon_e.ctl) begin
        bad++;
        $display("FAIL ctl txn=%0d act=%b exp=%b", txn, mon_a, mon_e.ctl);
      end
      total++;
      if (bus.stall_cnt_o !== mon_e.cnt) begin
        bad++;
        $display("FAIL stall_cnt txn=%0d act=%0d exp=%0d", txn, bus.stall_cnt_o, mon_e.cnt);
      end
      $display("txn %0d ctl=%b cnt=%0d", txn, mon_a, bus.stall_cnt_o);
      txn++;
    end
  end

  initial begin
    stim_t s;
    bus.ifid_rs1_i = '0; bus.ifid_rs2_i = '0; bus.idex_rd_i = '0; bus.idex_memread_i = 0;
    bus.exmem_branch_i = 0; bus.exmem_jump_i = 0; bus.exmem_comparison_i = 0;
    bus.exmem_memread_i = 0; bus.exmem_memwrite_i = 0; bus.dmem_ack_i = 0;

    // Reset, idle, load-use variants
    repeat (2) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 5, 3, 5, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 7, 7, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Branch taken / not taken / jump
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Memory wait with ack in the fourth cycle, then same-cycle ack
    repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    // Priorities
    step(mk(0, 5, 0, 5, 1, 0, 0, 0, 1, 0, 0));
    step(mk(0, 5, 0, 5, 1, 0, 0, 0, 1, 0, 1));
    step(mk(0, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0));
    // Timeout into sticky error, then reset clears it
    repeat (7) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Reset in the middle of a memory wait
    repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic; the memory request is held while the model is waiting on it
    for (int i = 0; i < 1500; i++) begin
      s.rst = m_err ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 149) == 0);
      s.rs1 = AW'($urandom_range(0, 7));
      s.rs2 = AW'($urandom_range(0, 7));
      s.rd  = AW'($urandom_range(0, 7));
      s.ld  = 1'($urandom_range(0, 1));
      s.br  = ($urandom_range(0, 5) == 0);
      s.jmp = ($urandom_range(0, 9) == 0);
      s.cmp = 1'($urandom_range(0, 1));
      if (m_wait && !m_err) begin
        s.mrd = last.mrd;
        s.mwr = last.mwr;
      end else begin
        s.mrd = ($urandom_range(0, 5) == 0);
        s.mwr = ($urandom_range(0, 7) == 0);
      end
      s.ack = ($urandom_range(0, 2) == 0);
      step(s);
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
